// File: rtl/oam_dma_controller.sv
// ----------------------------------------------------------------------------
// oam_dma_controller - Game Boy OAM DMA engine; DMA_RESTART_EN enables restart-on-write. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module oam_dma_controller #(
    parameter logic [15:0] DMA_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter int          XFER_LEN = 160
) (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    input  logic [15:0] I_IOREG_ADDR,
    inout  wire  [7:0]  IO_IOREG_DATA,
    input  logic        I_IOREG_WE_L,
    input  logic        I_IOREG_RE_L,
    output logic [15:0] O_MEM_ADDR,
    input  logic [7:0]  I_MEM_DATA,
    output logic        O_MEM_RE_L,
    output logic [15:0] O_OAM_ADDR,
    output logic [7:0]  O_OAM_DATA,
    output logic        O_OAM_WE_L,
    output logic        O_DMA_ACTIVE
);

`ifdef DMA_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  dma_reg;
    logic [7:0]  idx;
    logic [15:0] base;
    logic        kick;

    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  src_page;

    assign reg_wr = !I_IOREG_WE_L && (I_IOREG_ADDR == DMA_ADDR);
    assign reg_rd = !I_IOREG_RE_L && (I_IOREG_ADDR == DMA_ADDR);

    assign IO_IOREG_DATA = reg_rd ? dma_reg : 8'hzz;

    // Pages 0xE0-0xFF alias the 0xC000-0xDFFF work RAM echo region.
    assign src_page = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;

    // The register is latched on the write edge; the transfer is launched one
    // edge later from that registered value, so kick carries the request over.
    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state        <= IDLE;
            dma_reg      <= 8'h00;
            idx          <= 8'h00;
            base         <= 16'h0000;
            kick         <= 1'b0;
            O_MEM_ADDR   <= 16'h0000;
            O_MEM_RE_L   <= 1'b1;
            O_OAM_ADDR   <= 16'h0000;
            O_OAM_DATA   <= 8'h00;
            O_OAM_WE_L   <= 1'b1;
            O_DMA_ACTIVE <= 1'b0;
        end else begin
            if (reg_wr) begin
                dma_reg <= IO_IOREG_DATA;
            end
            kick <= reg_wr && (RESTART_EN || (state == IDLE));

            if (kick && (RESTART_EN || (state == IDLE))) begin
                state        <= START;
                idx          <= 8'h00;
                base         <= {src_page, 8'h00};
                O_MEM_RE_L   <= 1'b1;
                O_OAM_WE_L   <= 1'b1;
                O_DMA_ACTIVE <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        O_MEM_RE_L   <= 1'b1;
                        O_OAM_WE_L   <= 1'b1;
                        O_DMA_ACTIVE <= 1'b0;
                    end
                    START: begin
                        state      <= READ;
                        O_MEM_ADDR <= base + {8'h00, idx};
                        O_MEM_RE_L <= 1'b0;
                    end
                    READ: begin
                        state      <= WRITE;
                        O_MEM_RE_L <= 1'b1;
                        O_OAM_ADDR <= OAM_BASE + {8'h00, idx};
                        O_OAM_DATA <= I_MEM_DATA;
                        O_OAM_WE_L <= 1'b0;
                    end
                    WRITE: begin
                        O_OAM_WE_L <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state        <= IDLE;
                            O_DMA_ACTIVE <= 1'b0;
                        end else begin
                            state      <= READ;
                            idx        <= idx + 8'h01;
                            O_MEM_ADDR <= base + {8'h00, idx} + 16'h0001;
                            O_MEM_RE_L <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
// ----------------------------------------------------------------------------
// tb_oam_dma_controller - directed self-checking bench for oam_dma_controller. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_oam_dma_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] ioreg_addr;
    logic        ioreg_we_l;
    logic        ioreg_re_l;
    logic [7:0]  drv;
    logic        drv_en;
    wire  [7:0]  io_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_re_l;
    logic [15:0] oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we_l;
    logic        dma_active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cyc;

    logic [15:0] mem_log [0:511];
    logic [7:0]  oam_val [0:159];
    int rcount, wcount;
    int first_rd_cyc, first_wr_cyc, first_d0_cyc;
    int last_strobe;

    assign io_data  = drv_en ? drv : 8'hzz;
    assign mem_data = mem_addr[7:0] ^ 8'h5A;

    oam_dma_controller dut (
        .I_CLK         (clk),
        .I_RESET_L     (rst_n),
        .I_IOREG_ADDR  (ioreg_addr),
        .IO_IOREG_DATA (io_data),
        .I_IOREG_WE_L  (ioreg_we_l),
        .I_IOREG_RE_L  (ioreg_re_l),
        .O_MEM_ADDR    (mem_addr),
        .I_MEM_DATA    (mem_data),
        .O_MEM_RE_L    (mem_re_l),
        .O_OAM_ADDR    (oam_addr),
        .O_OAM_DATA    (oam_data),
        .O_OAM_WE_L    (oam_we_l),
        .O_DMA_ACTIVE  (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: strobe exclusivity, strict READ/WRITE alternation, logging.
    always @(negedge clk) begin
        if (!dma_active) last_strobe = 0;
        if (!mem_re_l || !oam_we_l) begin
            total++;
            if (!mem_re_l && !oam_we_l) begin
                bad++;
                $display("FAIL strobe_overlap: re_l=%b we_l=%b required not both low (cycle %0d)", mem_re_l, oam_we_l, cyc);
            end else if (!mem_re_l) begin
                if (last_strobe == 1) begin
                    bad++;
                    $display("FAIL strobe_order: read at %h follows a read, required a write between", mem_addr);
                end
                last_strobe = 1;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (first_d0_cyc < 0 && mem_addr[15:8] == 8'hD0) first_d0_cyc = cyc;
                if (rcount < 512) mem_log[rcount] = mem_addr;
                rcount++;
            end else begin
                if (last_strobe != 1) begin
                    bad++;
                    $display("FAIL strobe_order: write at %h without preceding read (last=%0d), required last=1", oam_addr, last_strobe);
                end
                last_strobe = 2;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (oam_addr >= 16'hFE00 && oam_addr <= 16'hFE9F) begin
                    oam_val[int'(oam_addr - 16'hFE00)] = oam_data;
                end else begin
                    bad++;
                    $display("FAIL oam_range: addr=%h required FE00..FE9F", oam_addr);
                end
                wcount++;
            end
        end
    end

    task automatic clear_logs();
        rcount = 0;
        wcount = 0;
        first_rd_cyc = -1;
        first_wr_cyc = -1;
        first_d0_cyc = -1;
        last_strobe  = 0;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ioreg_addr = a;
        drv        = d;
        drv_en     = 1'b1;
        ioreg_we_l = 1'b0;
        @(negedge clk);
        ioreg_we_l = 1'b1;
        drv_en     = 1'b0;
        ioreg_addr = 16'h0000;
        wr_cyc     = cyc;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [7:0] v);
        @(negedge clk);
        ioreg_addr = a;
        ioreg_re_l = 1'b0;
        #1;
        v = io_data;
        ioreg_re_l = 1'b1;
        ioreg_addr = 16'h0000;
    endtask

    // Counts negedge samples with dma_active high until it falls; end_cyc is
    // the cycle of the first low sample, or -1 if the bound expires.
    task automatic count_active(output int n, output int end_cyc);
        n = 0;
        end_cyc = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (dma_active) n++;
            else if (n > 0) begin
                end_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int target);
        for (int k = 0; k < 1000 && wcount < target; k++) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (mem_addr !== 16'h0000 || mem_re_l !== 1'b1 || oam_addr !== 16'h0000 ||
            oam_data !== 8'h00 || oam_we_l !== 1'b1 || dma_active !== 1'b0) begin
            bad++;
            $display("FAIL %s: mem_addr=%h re_l=%b oam_addr=%h oam_data=%h we_l=%b active=%b required 0000 1 0000 00 1 0",
                     tag, mem_addr, mem_re_l, oam_addr, oam_data, oam_we_l, dma_active);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        io_read(16'hFF46, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL reset_reg: read %h required 00", v);
        end
    endtask

    task automatic test_copy();
        int n, e;
        clear_logs();
        io_write(16'hFF46, 8'hC1);
        total++;
        if (dma_active !== 1'b0) begin
            bad++;
            $display("FAIL active_early: active=%b one cycle after write, required 0", dma_active);
        end
        count_active(n, e);
        total++;
        if (n != 321) begin
            bad++;
            $display("FAIL copy_active_len: %0d cycles required 321", n);
        end
        total++;
        if (rcount != 160 || wcount != 160) begin
            bad++;
            $display("FAIL copy_counts: reads=%0d writes=%0d required 160 160", rcount, wcount);
        end
        total++;
        if (first_rd_cyc - wr_cyc != 2 || first_wr_cyc - wr_cyc != 3) begin
            bad++;
            $display("FAIL copy_latency: read at +%0d write at +%0d required +2 +3",
                     first_rd_cyc - wr_cyc, first_wr_cyc - wr_cyc);
        end
        for (int i = 0; i < 160; i++) begin
            total++;
            if (oam_val[i] !== (8'(i) ^ 8'h5A) || mem_log[i] !== (16'hC100 + 16'(i))) begin
                bad++;
                $display("FAIL copy_byte[%0d]: oam=%h src=%h required %h %h",
                         i, oam_val[i], mem_log[i], 8'(i) ^ 8'h5A, 16'hC100 + 16'(i));
            end
        end
    endtask

    task automatic test_echo();
        logic [7:0] v;
        int n, e;
        clear_logs();
        io_write(16'hFF46, 8'hE3);
        io_read(16'hFF46, v);
        total++;
        if (v !== 8'hE3) begin
            bad++;
            $display("FAIL echo_readback: read %h required E3", v);
        end
        io_read(16'hFF47, v);
        total++;
        if (v === 8'hE3) begin
            bad++;
            $display("FAIL bus_hiz_addr: bus=%h at FF47, required not driven with E3", v);
        end
        ioreg_addr = 16'hFF46;
        #1;
        total++;
        if (io_data === 8'hE3) begin
            bad++;
            $display("FAIL bus_hiz_re: bus=%h with RE_L high, required not driven", io_data);
        end
        ioreg_addr = 16'h0000;
        count_active(n, e);
        total++;
        if (n != 319 || wcount != 160) begin
            bad++;
            $display("FAIL echo_len: remaining active=%0d writes=%0d required 319 160", n, wcount);
        end
        for (int i = 0; i < 160; i++) begin
            total++;
            if (mem_log[i] !== (16'hC300 + 16'(i))) begin
                bad++;
                $display("FAIL echo_src[%0d]: %h required %h", i, mem_log[i], 16'hC300 + 16'(i));
            end
        end
        io_read(16'hFF46, v);
        total++;
        if (v !== 8'hE3) begin
            bad++;
            $display("FAIL echo_reg_kept: read %h required E3", v);
        end
    endtask

    task automatic test_restart();
        logic [7:0] v;
        int n, e, w1;
        clear_logs();
        io_write(16'hFF46, 8'hC0);
        w1 = wr_cyc;
        wait_writes(50);
        io_write(16'hFF46, 8'hD0);
`ifdef DMA_RESTART_EN
        @(negedge clk);
        last_strobe = 0;
        total++;
        if (dma_active !== 1'b1) begin
            bad++;
            $display("FAIL restart_start: active=%b required 1", dma_active);
        end
        count_active(n, e);
        total++;
        if (e - wr_cyc != 322) begin
            bad++;
            $display("FAIL restart_len: active ended %0d cycles after write, required 322", e - wr_cyc);
        end
        total++;
        if (first_d0_cyc - wr_cyc != 2) begin
            bad++;
            $display("FAIL restart_d000: first D0 read at +%0d required +2", first_d0_cyc - wr_cyc);
        end
        total++;
        if (rcount < 1 || rcount > 512 || mem_log[rcount-1] !== 16'hD09F) begin
            bad++;
            $display("FAIL restart_last_src: reads=%0d required last D09F", rcount);
        end
`else
        count_active(n, e);
        total++;
        if (e - w1 != 322) begin
            bad++;
            $display("FAIL norestart_len: ended %0d cycles after first write, required 322", e - w1);
        end
        total++;
        if (rcount != 160 || mem_log[159] !== 16'hC09F) begin
            bad++;
            $display("FAIL norestart_src: reads=%0d last=%h required 160 C09F", rcount, mem_log[159]);
        end
        for (int i = 0; i < 160; i++) begin
            total++;
            if (mem_log[i][15:8] !== 8'hC0) begin
                bad++;
                $display("FAIL norestart_page[%0d]: %h required C0xx", i, mem_log[i]);
            end
        end
        repeat (10) @(negedge clk);
        total++;
        if (dma_active !== 1'b0 || rcount != 160) begin
            bad++;
            $display("FAIL norestart_no_new: active=%b reads=%0d required 0 160", dma_active, rcount);
        end
`endif
        io_read(16'hFF46, v);
        total++;
        if (v !== 8'hD0) begin
            bad++;
            $display("FAIL restart_reg: read %h required D0", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int rc, wc;
        clear_logs();
        io_write(16'hFF46, 8'hC2);
        wait_writes(80);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rc = rcount;
        wc = wcount;
        repeat (30) @(negedge clk);
        total++;
        if (rcount != rc || wcount != wc || dma_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: reads +%0d writes +%0d active=%b required +0 +0 0",
                     rcount - rc, wcount - wc, dma_active);
        end
        io_read(16'hFF46, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_reg: read %h required 00", v);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ioreg_addr = 16'h0000;
        ioreg_we_l = 1'b1;
        ioreg_re_l = 1'b1;
        drv        = 8'h00;
        drv_en     = 1'b0;
        clear_logs();
        test_reset();
        test_copy();
        test_echo();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
